muldiv_hilo_ctrl: RTL and testbench
===================================

// Module: muldiv_hilo_ctrl
// PURPOSE
//  Multi-cycle sequencer for mult/multu/div/divu and owner of the architectural HI/LO registers.
//  Sits beside the single-cycle ALU. The decode stage issues a request with a start pulse,
//  stalls on busy, and reads hi/lo (mfhi/mflo) once done has been seen.
//  Uses one shift-add / restoring-divide step per cycle over 32 iterations.
// PARAMETERS
//  WIDTH   32  operand width; hi and lo are each WIDTH bits
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request strobe; sampled only when busy==0
//  op        in   2      00 mult, 01 multu, 10 div, 11 divu
//  gr1       in   WIDTH  rs operand (multiplicand / dividend)
//  gr2       in   WIDTH  rt operand (multiplier / divisor)
//  busy      out  1      request in flight; new start ignored
//  done      out  1      one-cycle pulse; hi/lo hold the new result
//  div_zero  out  1      divisor was 0; valid while done==1
//  hi        out  WIDTH  HI register (product[63:32] / remainder)
//  lo        out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  - Reset (rst==1 at clk edge): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
//    Reset mid-operation aborts the operation with no hi/lo update.
//  - FSM states:
//    - IDLE: on start, latch op and |gr1|,|gr2| (magnitudes for signed ops, raw for unsigned);
//      latch result sign (mult: sign1^sign2; div: quotient sign1^sign2, remainder sign1).
//      Go to CALC, counter=0.
//    - IDLE shortcut: div/divu with gr2==0 goes directly to DONE with div_zero=1; hi/lo unchanged.
//    - CALC: one iteration per cycle; counter increments; leave when counter==WIDTH-1 -> SIGN.
//      mult: 2*WIDTH accumulator, add multiplicand if multiplier LSB==1, shift right.
//      div: restoring; shift remainder:quotient left, subtract divisor, keep if non-negative,
//      quotient bit = 1.
//    - SIGN: negate (two's complement) the product, quotient or remainder per latched signs;
//      write hi/lo at this edge; -> DONE.
//    - DONE: done=1 for exactly this cycle, busy=0; -> IDLE. A start sampled in DONE is
//      accepted as if in IDLE (back-to-back issue).
//  - busy=1 in CALC and SIGN only.
//  - Latency: start accepted at edge E; done high in the cycle after edge E+WIDTH+1 (34 cycles
//    for WIDTH=32). Divide-by-zero: done in the cycle after edge E.
//  - Arithmetic: signed div truncates toward zero; remainder takes the dividend's sign.
//    0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (no trap).
//    mult/multu give the full 64-bit product; no overflow flag.
//  - Operands are captured at start; gr1/gr2/op changes while busy have no effect.
//  - start while busy==1 is ignored (not queued). div_zero clears when leaving DONE.
// CONFIGURATION
//  MULDIV_MTHILO_EN defined:
//    - Adds inputs mthi, mtlo (1 bit each) and wdata (WIDTH).
//    - In IDLE/DONE, mthi writes hi<=wdata and mtlo writes lo<=wdata at the clock edge;
//      both may be high in the same cycle.
//    - Ignored while busy.
//    - mthi/mtlo together with start in the same cycle: start wins; the write is dropped.
//  MULDIV_MTHILO_EN undefined: ports absent; hi/lo change only on SIGN-state writes and reset.
// TESTING
//  1. multu gr1=0xFFFFFFFF gr2=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
//  2. mult gr1=-7 (0xFFFFFFF9) gr2=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
//  3. div gr1=-7 gr2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
//     divu gr1=7 gr2=2 -> lo=3, hi=1.
//  4. div gr1=5 gr2=0 -> done one cycle after start, div_zero=1, hi/lo unchanged;
//     div_zero=0 the following cycle.
//  5. Start mult 3*4, pulse start with other operands at cycle 10 (ignored), then assert rst
//     at cycle 20 -> busy=0, hi=lo=0, no done. Issue again: lo=12. Back-to-back start in the
//     DONE cycle is accepted.
//  6. (MULDIV_MTHILO_EN) mthi wdata=0x1234 in IDLE -> hi=0x1234 next cycle;
//     mtlo during busy -> lo unaffected.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/response bundle between decode and the mult/div sequencer.
// MULDIV_MTHILO_EN adds the mthi/mtlo write path (mthi, mtlo, wdata).
interface muldiv_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] gr1;
  logic [WIDTH-1:0] gr2;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_MTHILO_EN
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;

  modport master (
    output start, op, gr1, gr2, mthi, mtlo, wdata,
    input  busy, done, div_zero, hi, lo
  );
  modport slave (
    input  start, op, gr1, gr2, mthi, mtlo, wdata,
    output busy, done, div_zero, hi, lo
  );
`else
  modport master (
    output start, op, gr1, gr2,
    input  busy, done, div_zero, hi, lo
  );
  modport slave (
    input  start, op, gr1, gr2,
    output busy, done, div_zero, hi, lo
  );
`endif
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer owning HI/LO; one shift-add or restoring step per cycle.
// Optional feature macro: MULDIV_MTHILO_EN (mthi/mtlo direct writes to HI/LO).
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               rst,
  muldiv_hilo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             div_zero_reg;

  logic             accept;
  logic             busy;
  logic             done;
  logic             op_div;
  logic             op_signed;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             gr2_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand conditioning: signed ops work on magnitudes, signs are re-applied in SIGN.
  always_comb begin
    op_div    = bus.op[1];
    op_signed = ~bus.op[0];
    sign1     = op_signed & bus.gr1[WIDTH-1];
    sign2     = op_signed & bus.gr2[WIDTH-1];
    mag1      = sign1 ? ({WIDTH{1'b0}} - bus.gr1) : bus.gr1;
    mag2      = sign2 ? ({WIDTH{1'b0}} - bus.gr2) : bus.gr2;
    gr2_zero  = (bus.gr2 == {WIDTH{1'b0}});
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        done       = (state_reg == S_DONE);
        state_next = S_IDLE;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (op_div && gr2_zero) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = S_SIGN;
        end
      end
      S_SIGN: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Single-step datapath: acc_hi:acc_lo is the product accumulator or remainder:quotient pair.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH + 1){1'b0}});
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    prod      = {acc_hi_reg, acc_lo_reg};
    prod_fix  = neg_q_reg ? ({(2 * WIDTH){1'b0}} - prod) : prod;
    quo_fix   = neg_q_reg ? ({WIDTH{1'b0}} - acc_lo_reg) : acc_lo_reg;
    rem_fix   = neg_r_reg ? ({WIDTH{1'b0}} - acc_hi_reg) : acc_hi_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      opnd_reg     <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_zero_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            cnt_reg      <= '0;
            is_div_reg   <= op_div;
            neg_q_reg    <= sign1 ^ sign2;
            neg_r_reg    <= sign1;
            opnd_reg     <= op_div ? mag2 : mag1;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= op_div ? mag1 : mag2;
            div_zero_reg <= op_div && gr2_zero;
          end
`ifdef MULDIV_MTHILO_EN
          // A start in the same cycle takes priority and the move is dropped.
          else begin
            if (bus.mthi) hi_reg <= bus.wdata;
            if (bus.mtlo) lo_reg <= bus.wdata;
          end
`endif
        end
        S_CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div_reg) begin
            if (!div_diff[WIDTH]) begin
              acc_hi_reg <= div_diff[WIDTH-1:0];
              acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_reg <= div_shift[WIDTH-1:0];
              acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_reg <= mul_sum[WIDTH:1];
            acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
          end
        end
        S_SIGN: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed vectors plus randomized ops against a 64-bit arithmetic model.
module tb_muldiv_hilo_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_hilo_ctrl_if #(.WIDTH(W)) bus ();
  muldiv_hilo_ctrl #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Architectural reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l,
                                 output logic dz, output int lat);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dz  = 1'b0;
    lat = 34;
    case (o)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; lat = 1;
        end else if (o == 2'b10) begin
          q = 64'(sa / sb); r = 64'(sa % sb); l = q[31:0]; h = r[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  task automatic do_op(input bit b2b, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt, output logic [31:0] h,
                       output logic [31:0] l, output logic dz);
    if (!b2b) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.gr1 = a; bus.gr2 = b;
    lat = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0; bus.op = 2'($urandom); bus.gr1 = $urandom; bus.gr2 = $urandom;
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
    end while (bus.done !== 1'b1 && lat < 100);
    h = bus.hi; l = bus.lo; dz = bus.div_zero;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d", o, a, b, h, l, dz, lat, busy_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      mismatched++;
      $display("FAIL reset: busy/done/dz=%b%b%b hi=%h lo=%h, want 000 0 0",
               bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_spec_vectors();
    logic [1:0]  ops [5]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
    logic [31:0] ga [5]   = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] gb [5]   = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd2, 32'hFFFFFFFF};
    logic [31:0] eh [5]   = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0};
    logic [31:0] el [5]   = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3, 32'h80000000};
    int lat, bc;
    logic [31:0] h, l;
    logic dz;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, ops[i], ga[i], gb[i], lat, bc, h, l, dz);
      compared++;
      if (h !== eh[i] || l !== el[i] || dz !== 1'b0 || lat != 34 || bc != 33) begin
        mismatched++;
        $display("FAIL vector%0d: hi=%h lo=%h dz=%b lat=%0d busy=%0d, want hi=%h lo=%h dz=0 lat=34 busy=33",
                 i, h, l, dz, lat, bc, eh[i], el[i]);
      end
      m_hi = eh[i]; m_lo = el[i];
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic [31:0] h, l;
    logic dz;
    do_op(1'b0, 2'b10, 32'd5, 32'd0, lat, bc, h, l, dz);
    compared++;
    if (h !== m_hi || l !== m_lo || dz !== 1'b1 || lat != 1 || bc != 0) begin
      mismatched++;
      $display("FAIL div_zero: hi=%h lo=%h dz=%b lat=%0d busy=%0d, want hi=%h lo=%h dz=1 lat=1 busy=0",
               h, l, dz, lat, bc, m_hi, m_lo);
    end
    @(negedge clk);
    compared++;
    if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("FAIL div_zero_clear: dz=%b done=%b, want 0 0", bus.div_zero, bus.done);
    end
  endtask

  task automatic test_random();
    int lat, bc, elat;
    logic [31:0] h, l, a, b, xh, xl;
    logic [1:0] o;
    logic dz, edz;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 4))
        0: a = 32'h80000000; 1: a = 32'hFFFFFFFF; 2: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0; 1: b = 32'hFFFFFFFF; 2: b = 32'd1; 3: b = 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      xh = m_hi; xl = m_lo;
      ref_op(o, a, b, xh, xl, edz, elat);
      do_op(1'b0, o, a, b, lat, bc, h, l, dz);
      compared++;
      if (h !== xh || l !== xl || dz !== edz || lat != elat || bc != elat - 1) begin
        mismatched++;
        $display("FAIL random%0d op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d busy=%0d, want %h %h %b %0d %0d",
                 i, o, a, b, h, l, dz, lat, bc, xh, xl, edz, elat, elat - 1);
      end
      m_hi = xh; m_lo = xl;
      @(negedge clk);
      compared++;
      if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
        mismatched++;
        $display("FAIL done_pulse%0d: done=%b dz=%b, want 0 0", i, bus.done, bus.div_zero);
      end
    end
  endtask

  task automatic test_ignore();
    int lat, dones;
    logic [31:0] a, b, xh, xl;
    logic edz;
    int elat;
    a = $urandom; b = $urandom;
    xh = m_hi; xl = m_lo;
    ref_op(2'b01, a, b, xh, xl, edz, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.gr1 = a; bus.gr2 = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 10);
      bus.op = 2'b11; bus.gr1 = $urandom; bus.gr2 = 32'd3;
    end while (bus.done !== 1'b1 && lat < 100);
    bus.start = 1'b0;
    compared++;
    if (bus.hi !== xh || bus.lo !== xl || lat != 34) begin
      mismatched++;
      $display("FAIL ignore_start: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=34", bus.hi, bus.lo, lat, xh, xl);
    end
    m_hi = xh; m_lo = xl;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    compared++;
    if (dones != 0) begin
      mismatched++;
      $display("FAIL ignore_not_queued: activity cycles=%0d, want 0", dones);
    end
    $display("ignore: multu a=%h b=%h hi=%h lo=%h lat=%0d", a, b, xh, xl, lat);
  endtask

  task automatic test_abort();
    int dones, lat, bc;
    logic [31:0] h, l;
    logic dz;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.gr1 = 32'd3; bus.gr2 = 32'd4;
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = (c == 10);
      bus.gr1 = 32'd5; bus.gr2 = 32'd6;
      if (bus.done === 1'b1) dones++;
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    compared++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      mismatched++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    compared++;
    if (dones != 0) begin
      mismatched++;
      $display("FAIL abort_no_done: done pulses=%0d, want 0", dones);
    end
    do_op(1'b0, 2'b00, 32'd3, 32'd4, lat, bc, h, l, dz);
    compared++;
    if (h !== 32'd0 || l !== 32'd12 || lat != 34) begin
      mismatched++;
      $display("FAIL abort_reissue: hi=%h lo=%h lat=%0d, want 0 12 34", h, l, lat);
    end
    m_hi = h; m_lo = l;
  endtask

  task automatic test_back_to_back();
    int lat, bc, elat;
    logic [31:0] h, l, xh, xl;
    logic dz, edz;
    logic [1:0]  ops [4] = '{2'b00, 2'b10, 2'b11, 2'b11};
    logic [31:0] ga [4];
    logic [31:0] gb [4];
    for (int i = 0; i < 4; i++) begin
      ga[i] = $urandom;
      gb[i] = (i >= 2) ? 32'd0 : $urandom;
    end
    do_op(1'b0, 2'b01, 32'd9, 32'd9, lat, bc, h, l, dz);
    m_hi = 32'd0; m_lo = 32'd81;
    for (int i = 0; i < 4; i++) begin
      xh = m_hi; xl = m_lo;
      ref_op(ops[i], ga[i], gb[i], xh, xl, edz, elat);
      do_op(1'b1, ops[i], ga[i], gb[i], lat, bc, h, l, dz);
      compared++;
      if (h !== xh || l !== xl || dz !== edz || lat != elat) begin
        mismatched++;
        $display("FAIL back_to_back%0d: hi=%h lo=%h dz=%b lat=%0d, want %h %h %b %0d",
                 i, h, l, dz, lat, xh, xl, edz, elat);
      end
      m_hi = xh; m_lo = xl;
    end
  endtask

`ifdef MULDIV_MTHILO_EN
  task automatic test_mthilo();
    int lat, moved;
    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    m_hi = 32'h1234;
    compared++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      mismatched++;
      $display("FAIL mthi: hi=%h lo=%h, want %h %h", bus.hi, bus.lo, m_hi, m_lo);
    end
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = $urandom;
    @(negedge clk);
    m_hi = bus.wdata; m_lo = bus.wdata;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    compared++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      mismatched++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, want %h %h", bus.hi, bus.lo, m_hi, m_lo);
    end
    bus.start = 1'b1; bus.op = 2'b01; bus.gr1 = 32'd3; bus.gr2 = 32'd5;
    bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
    lat = 0; moved = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      bus.wdata = $urandom;
      if (bus.busy === 1'b1 && bus.lo !== m_lo) moved++;
      if (bus.done === 1'b1) bus.mtlo = 1'b0;
    end while (bus.done !== 1'b1 && lat < 100);
    bus.mtlo = 1'b0;
    compared++;
    if (moved != 0 || bus.lo !== 32'd15 || bus.hi !== 32'd0) begin
      mismatched++;
      $display("FAIL mtlo_busy: lo changed %0d cycles, hi=%h lo=%h, want 0 changes 0 f", moved, bus.hi, bus.lo);
    end
    m_hi = 32'd0; m_lo = 32'd15;
    $display("mthilo: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.gr1 = '0; bus.gr2 = '0;
`ifdef MULDIV_MTHILO_EN
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
`endif
    test_reset();
    test_spec_vectors();
    test_div_zero();
    test_random();
    test_ignore();
    test_abort();
    test_back_to_back();
`ifdef MULDIV_MTHILO_EN
    test_mthilo();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
